ysyx_25060173_bitscan_encoder: RTL and testbench

YSYX_25060173_BITSCAN_ENCODER -- requirements
Module: ysyx_25060173_bitscan_encoder

---
 rtl/ysyx_25060173_bitscan_encoder.sv | 133 +++++++++++++
 tb/tb_ysyx_25060173_bitscan_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060173_bitscan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25060173_bitscan_encoder
// Description : Accepts a multi-hot vector and emits the binary index of each
//               set bit, one per handshake, together with a "last" flag and
//               the count of set bits still pending (current one included).
//               Every output is a function of the state and mask registers
//               only, so nothing on the input side reaches an output
//               combinationally.
// Options     : YSYX_25060173_BITSCAN_MSB_FIRST_EN - when defined, indices
//               are produced highest-first; otherwise lowest-first.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25060173_bitscan_encoder #(
  parameter int INPUT_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [(1<<INPUT_WIDTH)-1:0]   in_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INPUT_WIDTH-1:0]        out_idx,
  output logic                          out_last,
  output logic [INPUT_WIDTH:0]          out_cnt
);

  localparam int                   N       = 1 << INPUT_WIDTH;
  localparam logic [INPUT_WIDTH:0] CNT_ONE = {{INPUT_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [N-1:0]           mask_q;
  logic [N-1:0]           mask_d;

  logic [INPUT_WIDTH-1:0] sel_idx;     // index chosen from the pending mask
  logic [N-1:0]           sel_onehot;  // that index as a clear mask
  logic [INPUT_WIDTH:0]   pop_cnt;     // set bits left in the mask
  logic                   in_fire;
  logic                   out_fire;
  logic                   scanning;

  // Pick the next index to report; the final assignment in the loop wins,
  // so the loop direction sets the scan order.
  always_comb begin
    sel_idx = '0;
`ifdef YSYX_25060173_BITSCAN_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (mask_q[i]) begin
        sel_idx = INPUT_WIDTH'(i);
      end
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_idx = INPUT_WIDTH'(i);
      end
    end
`endif
  end

  // Decode the selected index back to a one-hot vector for clearing.
  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  // Population count of the pending mask; one extra bit holds the all-ones case.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + {{INPUT_WIDTH{1'b0}}, mask_q[i]};
    end
  end

  // Outputs come purely from registered state; IDLE forces them to zero.
  always_comb begin
    scanning  = (state_q == ST_SCAN);
    in_ready  = ~scanning;
    out_valid = scanning;
    out_idx   = scanning ? sel_idx : '0;
    out_cnt   = scanning ? pop_cnt : '0;
    out_last  = scanning && (pop_cnt == CNT_ONE);
  end

  // Next-state and mask update: load on accept, clear one bit per handshake.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    case (state_q)
      ST_IDLE: begin
        // An all-zero vector is swallowed without producing any output.
        if (in_fire && (in_vec != '0)) begin
          mask_d  = in_vec;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (out_fire) begin
          mask_d = mask_q & ~sel_onehot;
          if (out_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  // State and mask registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060173_bitscan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25060173_bitscan_encoder
// Description : Scoreboard bench for the bit-scan encoder. Stimulus pushes
//               hand-computed expected indices into a queue; a monitor on the
//               falling edge compares whatever the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060173_bitscan_encoder;

  localparam int IW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [IW:0]   out_cnt;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          last;
    logic [IW:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   noise = 1'b0;

  ysyx_25060173_bitscan_encoder #(.INPUT_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input int idx, input bit last, input int cnt);
    exp_t e;
    e.idx  = idx[IW-1:0];
    e.last = last;
    e.cnt  = cnt[IW:0];
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Called at posedge+1; holds in_valid until the accepting edge has passed.
  task automatic accept(input logic [N-1:0] v);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_vec   = v;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = '0;
  endtask

  // With out_ready high, k handshakes follow; in_ready rises only after the last.
  task automatic scan_check(input int k);
    for (int j = 1; j <= k; j++) begin
      if (noise) begin
        in_valid = 1'b1;
        in_vec   = N'($urandom);
      end
      @(posedge clk); #1;
      check("in_ready_scan", {31'd0, in_ready}, {31'd0, (j == k)});
    end
    in_valid = 1'b0;
    in_vec   = '0;
  endtask

  task automatic expect_a4();
`ifdef YSYX_25060173_BITSCAN_MSB_FIRST_EN
    expect_out(7, 1'b0, 3);
    expect_out(5, 1'b0, 2);
    expect_out(2, 1'b1, 1);
`else
    expect_out(2, 1'b0, 3);
    expect_out(5, 1'b0, 2);
    expect_out(7, 1'b1, 1);
`endif
  endtask

  // Monitor: compare every presented output to the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got idx=%0d last=%0d cnt=%0d, required no output",
                 out_idx, out_last, out_cnt);
      end else begin
        mon_e = exp_q[0];
        if ({out_idx, out_last, out_cnt} !== mon_e) begin
          n_err++;
          $display("FAIL out_beat: got idx=%0d last=%0d cnt=%0d, required idx=%0d last=%0d cnt=%0d",
                   out_idx, out_last, out_cnt, mon_e.idx, mon_e.last, mon_e.cnt);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset state, visible before any clock edge.
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_out_cnt",   {28'd0, out_cnt},   32'd0);
    check("rst_out_idx",   {29'd0, out_idx},   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // 8'hA4 streamed at full rate.
    expect_a4();
    accept(8'hA4);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    scan_check(3);

    // All-zero vector is consumed silently.
    accept(8'h00);
    for (int j = 0; j < 3; j++) begin
      check("zero_vec_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end

    // 8'h81 with a three-cycle stall; monitor checks the held beat each cycle.
`ifdef YSYX_25060173_BITSCAN_MSB_FIRST_EN
    expect_out(7, 1'b0, 2);
    expect_out(0, 1'b1, 1);
`else
    expect_out(0, 1'b0, 2);
    expect_out(7, 1'b1, 1);
`endif
    out_ready = 1'b0;
    accept(8'h81);
    repeat (3) @(posedge clk);
    #1;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    scan_check(2);

    // All ones: eight beats, count starts at N.
    for (int j = 0; j < 8; j++) begin
`ifdef YSYX_25060173_BITSCAN_MSB_FIRST_EN
      expect_out(7 - j, (j == 7), 8 - j);
`else
      expect_out(j, (j == 7), 8 - j);
`endif
    end
    accept(8'hFF);
    scan_check(8);

    // Input activity during a scan must not disturb it.
    noise = 1'b1;
    expect_a4();
    accept(8'hA4);
    scan_check(3);
    noise = 1'b0;

    // Asynchronous reset during the second beat of 8'hA4.
`ifdef YSYX_25060173_BITSCAN_MSB_FIRST_EN
    expect_out(7, 1'b0, 3);
`else
    expect_out(2, 1'b0, 3);
`endif
    accept(8'hA4);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("async_rst_out_cnt",   {28'd0, out_cnt},   32'd0);
    check("async_rst_out_idx",   {29'd0, out_idx},   32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_queue_empty", exp_q.size(), 32'd0);
    expect_out(4, 1'b1, 1);
    accept(8'h10);
    check("post_rst_accept", {31'd0, in_ready}, 32'd0);
    scan_check(1);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
